pipe_stage_chain: RTL and testbench
===================================

Name: pipe_stage_chain

Overview:
Parametrised elastic pipeline-register chain for the next-generation core datapath. It replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers with one configurable block. Carries WIDTH-bit payload plus destination-register tag and regWrite flag through STAGES slots, with valid/ready backpressure, per-stage flush, and a built-in forwarding lookup that returns the youngest in-flight result for a queried register.

Parameters:
DATA_W, 32, payload width (result data), >=1
TAG_W, 5, destination-register tag width
STAGES, 4, number of pipeline slots, >=1
ZERO_TAG_FWD, 0, 1 = tag 0 may match on forwarding lookup; 0 = tag 0 never hits (MIPS $zero)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  upstream item present
in_ready  out  1  chain accepts item this cycle
in_data  in  DATA_W  payload
in_tag  in  TAG_W  destination register
in_wr  in  1  item writes a register
out_valid  out  1  last slot holds a live item
out_ready  in  1  downstream accepts
out_data  out  DATA_W  last-slot payload
out_tag  out  TAG_W  last-slot tag
out_wr  out  1  last-slot write flag
flush  in  STAGES  per-slot kill, bit 0 = youngest slot
query_tag  in  TAG_W  register to look up
hit_vec  out  STAGES  per-slot match
hit_any  out  1  OR of hit_vec
fwd_data  out  DATA_W  payload of youngest matching slot, 0 if none
occupancy  out  $clog2(STAGES+1)  count of valid slots

Behaviour:
- Reset: all slot valid bits 0, slot data/tag/wr 0. Result: out_valid=0, out_data=0, out_tag=0, out_wr=0, occupancy=0, hit_vec=0, fwd_data=0. in_ready=1 once rst is low. Reset mid-operation drops every in-flight item with no output handshake.
- Effective valid: ev[i] = valid[i] & ~flush[i]. A flushed slot behaves as empty for that cycle.
- Ready chain (combinational): rdy[STAGES] = out_ready; rdy[i] = ~ev[i] | rdy[i+1]; in_ready = rdy[0]. Bubbles collapse, so a slot fills when it is empty or draining.
- Slot update at posedge when rdy[i]:
  - slot 0 loads {in_valid, in_data, in_tag, in_wr}.
  - slot i>0 loads {ev[i-1], contents of slot i-1}.
  - When ~rdy[i], the slot holds, except valid[i] <= ev[i] (a flush still clears a stalled slot).
- Flush kills only the item held in slot i at that edge; an item entering slot i on the same edge is kept. Simultaneous flush of every bit empties the chain in one cycle.
- out_valid = ev[STAGES-1]; out_data/out_tag/out_wr come straight from the last slot.
- Output handshake: fires when out_valid & out_ready. When out_valid=1 and out_ready=0, out_* hold stable.
- Latency: STAGES cycles from in handshake to out_valid with no backpressure. Throughput is 1 item/cycle.
- Slot data is don't-care while invalid, but hit logic must ignore it.
- hit_vec[i] = ev[i] & wr[i] & (tag[i]==query_tag) & (ZERO_TAG_FWD | query_tag!=0).
- fwd_data selects the lowest-index hit (youngest). Combinational, same-cycle.
- occupancy = popcount(valid), registered view, before flush masking.
- STAGES=1: single register slot with the same rules; the ready chain degenerates to ~ev[0] | out_ready.

Optional Feature:
Macro PIPE_PERF_EN.
- Defined: two 32-bit saturating counters.
  - perf_stall counts cycles with out_valid & ~out_ready.
  - perf_bubble counts cycles with ~out_valid.
  - Both clear on rst and on input perf_clr (1 bit, synchronous); they stick at 32'hFFFFFFFF.
  - Extra ports: perf_clr in, perf_stall out 32, perf_bubble out 32.
- Undefined: those ports and counters are absent; all other behaviour is identical.

Test Plan:
- Stream: rst, then in_valid=1 with data 1,2,3,4,5 and out_ready=1 (STAGES=4) -> out_valid rises 4 cycles after the first accept; out_data is 1..5 on consecutive cycles; occupancy reaches 4.
- Backpressure: fill with 4 items, out_ready=0 -> in_ready=0, out_data held, occupancy=4. Release out_ready -> one item per cycle with no loss or duplication.
- Flush: items A,B,C in slots 0..2, pulse flush=4'b0010 for one cycle -> B never appears at the output, output order is A then C, occupancy drops by 1.
- Forwarding: slots hold (tag 5, wr 1, data 0x11) in slot 2 and (tag 5, wr 1, data 0x22) in slot 0, query_tag=5 -> hit_vec=4'b0101, fwd_data=0x22. With query_tag=0 and ZERO_TAG_FWD=0 -> hit_any=0 even when a slot holds tag 0 with wr=1.
- Reset mid-stream: rst high for one cycle with 3 items in flight -> next cycle out_valid=0, occupancy=0, in_ready=1.
- PIPE_PERF_EN: hold out_ready=0 for 10 cycles with a full chain -> perf_stall=10; perf_clr pulse -> 0.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: elastic valid/ready register chain with per-slot flush and forwarding lookup.
// Define PIPE_PERF_EN to add saturating stall/bubble performance counters.
module pipe_stage_chain #(
    parameter int DATA_W       = 32,
    parameter int TAG_W        = 5,
    parameter int STAGES       = 4,
    parameter int ZERO_TAG_FWD = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic [TAG_W-1:0]             in_tag,
    input  logic                         in_wr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [TAG_W-1:0]             out_tag,
    output logic                         out_wr,
    input  logic [STAGES-1:0]            flush,
    input  logic [TAG_W-1:0]             query_tag,
    output logic [STAGES-1:0]            hit_vec,
    output logic                         hit_any,
    output logic [DATA_W-1:0]            fwd_data,
    output logic [$clog2(STAGES+1)-1:0]  occupancy
`ifdef PIPE_PERF_EN
   ,input  logic                         perf_clr,
    output logic [31:0]                  perf_stall,
    output logic [31:0]                  perf_bubble
`endif
);
    localparam int OCC_W = $clog2(STAGES+1);

    logic              r_valid [STAGES];
    logic              r_wr    [STAGES];
    logic [DATA_W-1:0] r_data  [STAGES];
    logic [TAG_W-1:0]  r_tag   [STAGES];
    logic              w_src_v [STAGES];
    logic              w_src_w [STAGES];
    logic [DATA_W-1:0] w_src_d [STAGES];
    logic [TAG_W-1:0]  w_src_t [STAGES];
    logic [STAGES-1:0] w_ev;
    logic [STAGES-1:0] w_rdy;

    for (genvar i = 0; i < STAGES; i++) begin : g_slot
        assign w_ev[i]    = r_valid[i] & ~flush[i];
        // A slot can advance unless it and every slot ahead of it is live and the sink stalls.
        assign w_rdy[i]   = out_ready | ~(&w_ev[STAGES-1:i]);
        assign hit_vec[i] = w_ev[i] & r_wr[i] & (r_tag[i] == query_tag) &
                            (ZERO_TAG_FWD != 0 || query_tag != '0);
        if (i == 0) begin : g_head
            assign w_src_v[i] = in_valid;
            assign w_src_w[i] = in_wr;
            assign w_src_d[i] = in_data;
            assign w_src_t[i] = in_tag;
        end else begin : g_body
            assign w_src_v[i] = w_ev[i-1];
            assign w_src_w[i] = r_wr[i-1];
            assign w_src_d[i] = r_data[i-1];
            assign w_src_t[i] = r_tag[i-1];
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid[i] <= 1'b0;
                r_wr[i]    <= 1'b0;
                r_data[i]  <= '0;
                r_tag[i]   <= '0;
            end else if (w_rdy[i]) begin
                r_valid[i] <= w_src_v[i];
                r_wr[i]    <= w_src_w[i];
                r_data[i]  <= w_src_d[i];
                r_tag[i]   <= w_src_t[i];
            end else begin
                r_valid[i] <= w_ev[i];
            end
        end
    end

    assign in_ready  = w_rdy[0];
    assign out_valid = w_ev[STAGES-1];
    assign out_data  = r_data[STAGES-1];
    assign out_tag   = r_tag[STAGES-1];
    assign out_wr    = r_wr[STAGES-1];
    assign hit_any   = |hit_vec;

    // Scanning oldest to youngest lets the youngest hit overwrite older ones.
    always_comb begin
        fwd_data  = '0;
        occupancy = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            fwd_data  = hit_vec[k] ? r_data[k] : fwd_data;
            occupancy = occupancy + OCC_W'(r_valid[k]);
        end
    end

`ifdef PIPE_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_bubble;

    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            r_perf_stall  <= '0;
            r_perf_bubble <= '0;
        end else begin
            if (out_valid && !out_ready && !(&r_perf_stall))
                r_perf_stall <= r_perf_stall + 32'd1;
            if (!out_valid && !(&r_perf_bubble))
                r_perf_bubble <= r_perf_bubble + 32'd1;
        end
    end

    assign perf_stall  = r_perf_stall;
    assign perf_bubble = r_perf_bubble;
`endif
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: directed and randomized checks against an item-level model of the chain.
// Perf counter checks are compiled in when PIPE_PERF_EN is defined.
module tb_pipe_stage_chain;
    localparam int S  = 4;
    localparam int DW = 32;
    localparam int TW = 5;
    localparam int ZT = 0;
    localparam int OW = $clog2(S+1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [TW-1:0] in_tag = '0;
    logic          in_wr = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [TW-1:0] out_tag;
    logic          out_wr;
    logic [S-1:0]  flush = '0;
    logic [TW-1:0] query_tag = '0;
    logic [S-1:0]  hit_vec;
    logic          hit_any;
    logic [DW-1:0] fwd_data;
    logic [OW-1:0] occupancy;
`ifdef PIPE_PERF_EN
    logic          perf_clr = 1'b0;
    logic [31:0]   perf_stall;
    logic [31:0]   perf_bubble;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    pipe_stage_chain #(.DATA_W(DW), .TAG_W(TW), .STAGES(S), .ZERO_TAG_FWD(ZT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag), .in_wr(in_wr),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag), .out_wr(out_wr),
        .flush(flush), .query_tag(query_tag), .hit_vec(hit_vec), .hit_any(hit_any),
        .fwd_data(fwd_data), .occupancy(occupancy)
`ifdef PIPE_PERF_EN
       ,.perf_clr(perf_clr), .perf_stall(perf_stall), .perf_bubble(perf_bubble)
`endif
    );

    always #5 clk = ~clk;

    // Model: each slot either holds an item or is empty; items advance into free space.
    bit            m_v [S];
    bit            m_w [S];
    logic [DW-1:0] m_d [S];
    logic [TW-1:0] m_t [S];
    bit            n_v [S];
    bit            n_w [S];
    logic [DW-1:0] n_d [S];
    logic [TW-1:0] n_t [S];
    bit            e_in_ready;
    bit            e_out_valid;
    logic [S-1:0]  e_hit;
    logic [DW-1:0] e_fwd;
    int            e_occ;

    task automatic mdl_calc();
        bit live [S];
        bit found;
        int dst;
        e_occ = 0;
        e_hit = '0;
        e_fwd = '0;
        found = 0;
        for (int i = 0; i < S; i++) begin
            live[i] = m_v[i] && !flush[i];
            e_occ += int'(m_v[i]);
            n_v[i] = 0; n_w[i] = 0; n_d[i] = '0; n_t[i] = '0;
            if (live[i] && m_w[i] && m_t[i] == query_tag && (ZT != 0 || query_tag != 0)) begin
                e_hit[i] = 1'b1;
                if (!found) e_fwd = m_d[i];
                found = 1;
            end
        end
        e_out_valid = live[S-1];
        for (int i = S - 1; i >= 0; i--) begin
            if (live[i]) begin
                if (i == S - 1) dst = out_ready ? -1 : i;
                else dst = n_v[i+1] ? i : i + 1;
                if (dst >= 0) begin
                    n_v[dst] = 1; n_w[dst] = m_w[i]; n_d[dst] = m_d[i]; n_t[dst] = m_t[i];
                end
            end
        end
        e_in_ready = !n_v[0];
        if (e_in_ready && in_valid) begin
            n_v[0] = 1; n_w[0] = in_wr; n_d[0] = in_data; n_t[0] = in_tag;
        end
        if (rst) begin
            for (int i = 0; i < S; i++) begin
                n_v[i] = 0; n_w[i] = 0; n_d[i] = '0; n_t[i] = '0;
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        mdl_calc();
    endtask

    task automatic tick();
        mdl_calc();
        @(posedge clk);
        for (int i = 0; i < S; i++) begin
            m_v[i] = n_v[i]; m_w[i] = n_w[i]; m_d[i] = n_d[i]; m_t[i] = n_t[i];
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] d, input logic [TW-1:0] t, input bit w, input bit ordy);
        in_valid = v; in_data = d; in_tag = t; in_wr = w; out_ready = ordy;
    endtask

    task automatic idle(input int n);
        drive(0, '0, '0, 0, 1);
        flush = '0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic test_reset();
        for (int i = 0; i < S; i++) begin
            m_v[i] = 0; m_w[i] = 0; m_d[i] = '0; m_t[i] = '0;
        end
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        settle();
        n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
        n_chk++; if (out_data !== '0) $display("FAIL reset_out_data got %h exp 0", out_data); else n_pass++;
        n_chk++; if (out_tag !== '0 || out_wr !== 1'b0) $display("FAIL reset_out_tag_wr got %h/%b exp 0/0", out_tag, out_wr); else n_pass++;
        n_chk++; if (occupancy !== '0) $display("FAIL reset_occupancy got %0d exp 0", occupancy); else n_pass++;
        n_chk++; if (hit_vec !== '0 || fwd_data !== '0) $display("FAIL reset_fwd got %b/%h exp 0/0", hit_vec, fwd_data); else n_pass++;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else n_pass++;
        tick();
    endtask

    task automatic test_stream();
        for (int c = 0; c < 10; c++) begin
            drive(c < 5, DW'(c + 1), 5'd3, 1, 1);
            settle();
            n_chk++;
            if (out_valid !== (c >= 4 && c <= 8)) $display("FAIL stream_valid c=%0d got %b exp %b", c, out_valid, (c >= 4 && c <= 8));
            else n_pass++;
            if (c >= 4 && c <= 8) begin
                n_chk++; if (out_data !== DW'(c - 3)) $display("FAIL stream_data c=%0d got %h exp %h", c, out_data, c - 3); else n_pass++;
            end
            if (c == 4) begin
                n_chk++; if (occupancy !== OW'(4)) $display("FAIL stream_occupancy got %0d exp 4", occupancy); else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 4; k++) begin
            drive(1, DW'(k + 1), 5'd2, 1, 0);
            settle();
            n_chk++; if (in_ready !== 1'b1) $display("FAIL bp_fill_ready k=%0d got %b exp 1", k, in_ready); else n_pass++;
            tick();
        end
        drive(1, 32'd99, 5'd2, 1, 0);
        for (int k = 0; k < 3; k++) begin
            settle();
            n_chk++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %b exp 0", in_ready); else n_pass++;
            n_chk++; if (occupancy !== OW'(4)) $display("FAIL bp_occupancy got %0d exp 4", occupancy); else n_pass++;
            n_chk++; if (out_valid !== 1'b1 || out_data !== 32'd1) $display("FAIL bp_hold got %b/%h exp 1/1", out_valid, out_data); else n_pass++;
            tick();
        end
        drive(0, '0, '0, 0, 1);
        for (int k = 0; k < 5; k++) begin
            settle();
            n_chk++; if (out_valid !== (k < 4)) $display("FAIL bp_drain_valid k=%0d got %b exp %b", k, out_valid, k < 4); else n_pass++;
            if (k < 4) begin
                n_chk++; if (out_data !== DW'(k + 1)) $display("FAIL bp_drain_data k=%0d got %h exp %h", k, out_data, k + 1); else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_flush();
        logic [DW-1:0] got [$];
        logic [DW-1:0] items [3] = '{32'hA0, 32'hB0, 32'hC0};
        for (int k = 0; k < 3; k++) begin
            drive(1, items[k], 5'd1, 1, 1);
            tick();
        end
        drive(0, '0, '0, 0, 1);
        flush = 4'b0010;
        settle();
        n_chk++; if (occupancy !== OW'(3)) $display("FAIL flush_occ_before got %0d exp 3", occupancy); else n_pass++;
        tick();
        flush = '0;
        for (int k = 0; k < 8; k++) begin
            settle();
            if (k == 0) begin
                n_chk++; if (occupancy !== OW'(2)) $display("FAIL flush_occ_after got %0d exp 2", occupancy); else n_pass++;
            end
            if (out_valid === 1'b1 && out_ready) got.push_back(out_data);
            tick();
        end
        n_chk++;
        if (got.size() != 2) $display("FAIL flush_count got %0d exp 2", got.size());
        else if (got[0] !== 32'hA0 || got[1] !== 32'hC0) $display("FAIL flush_order got %h,%h exp a0,c0", got[0], got[1]);
        else n_pass++;
    endtask

    task automatic test_forwarding();
        drive(1, 32'h11, 5'd5, 1, 1); tick();
        drive(1, 32'h33, 5'd0, 1, 1); tick();
        drive(1, 32'h22, 5'd5, 1, 1); tick();
        drive(0, '0, '0, 0, 0);
        query_tag = 5'd5;
        settle();
        n_chk++; if (hit_vec !== 4'b0101) $display("FAIL fwd_hit_vec got %b exp 0101", hit_vec); else n_pass++;
        n_chk++; if (fwd_data !== 32'h22) $display("FAIL fwd_data got %h exp 22", fwd_data); else n_pass++;
        n_chk++; if (hit_any !== 1'b1) $display("FAIL fwd_hit_any got %b exp 1", hit_any); else n_pass++;
        query_tag = 5'd0;
        #1;
        n_chk++; if (hit_any !== 1'b0 || hit_vec !== '0) $display("FAIL fwd_zero_tag got %b/%b exp 0/0000", hit_any, hit_vec); else n_pass++;
        n_chk++; if (fwd_data !== '0) $display("FAIL fwd_zero_data got %h exp 0", fwd_data); else n_pass++;
        idle(6);
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            drive(1, DW'(k + 40), 5'd7, 1, 0);
            tick();
        end
        drive(0, '0, '0, 0, 0);
        settle();
        n_chk++; if (occupancy !== OW'(3)) $display("FAIL rstmid_occ_before got %0d exp 3", occupancy); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        n_chk++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid got %b exp 0", out_valid); else n_pass++;
        n_chk++; if (occupancy !== '0) $display("FAIL rstmid_occ got %0d exp 0", occupancy); else n_pass++;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready got %b exp 1", in_ready); else n_pass++;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(63) == 0);
            drive($urandom_range(1), $urandom, TW'($urandom_range(3)), $urandom_range(1), $urandom_range(9) < 7);
            flush = ($urandom_range(7) == 0) ? S'($urandom) : '0;
            query_tag = TW'($urandom_range(3));
            settle();
            n_chk++; if (in_ready !== e_in_ready) $display("FAIL rnd_in_ready c=%0d got %b exp %b", c, in_ready, e_in_ready); else n_pass++;
            n_chk++; if (out_valid !== e_out_valid) $display("FAIL rnd_out_valid c=%0d got %b exp %b", c, out_valid, e_out_valid); else n_pass++;
            n_chk++; if (occupancy !== OW'(e_occ)) $display("FAIL rnd_occupancy c=%0d got %0d exp %0d", c, occupancy, e_occ); else n_pass++;
            n_chk++; if (hit_vec !== e_hit || hit_any !== |e_hit) $display("FAIL rnd_hit c=%0d got %b/%b exp %b", c, hit_vec, hit_any, e_hit); else n_pass++;
            n_chk++; if (fwd_data !== e_fwd) $display("FAIL rnd_fwd_data c=%0d got %h exp %h", c, fwd_data, e_fwd); else n_pass++;
            if (e_out_valid) begin
                n_chk++;
                if (out_data !== m_d[S-1] || out_tag !== m_t[S-1] || out_wr !== m_w[S-1])
                    $display("FAIL rnd_out_item c=%0d got %h/%h/%b exp %h/%h/%b", c, out_data, out_tag, out_wr, m_d[S-1], m_t[S-1], m_w[S-1]);
                else n_pass++;
            end
            tick();
        end
        rst = 1'b0;
        flush = '0;
        idle(S + 1);
    endtask

`ifdef PIPE_PERF_EN
    task automatic test_perf();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1, DW'(k), 5'd1, 1, 0);
            tick();
        end
        drive(0, '0, '0, 0, 0);
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        settle();
        n_chk++; if (perf_stall !== 32'd0) $display("FAIL perf_clr_first got %0d exp 0", perf_stall); else n_pass++;
        for (int k = 0; k < 10; k++) tick();
        settle();
        n_chk++; if (perf_stall !== 32'd10) $display("FAIL perf_stall got %0d exp 10", perf_stall); else n_pass++;
        n_chk++; if (perf_bubble !== 32'd0) $display("FAIL perf_bubble got %0d exp 0", perf_bubble); else n_pass++;
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        settle();
        n_chk++; if (perf_stall !== 32'd0) $display("FAIL perf_clr got %0d exp 0", perf_stall); else n_pass++;
        idle(S + 1);
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_forwarding();
        test_reset_mid();
        test_random();
`ifdef PIPE_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
